serial_adder: RTL

Bit-serial WIDTH-bit adder built around a single one-bit full-adder cell and a carry flip-flop. It accepts two parallel operands and a carry-in on a start handshake, then feeds one bit pair per clock, LSB first, through the full-adder cell. The result is accumulated in a shift register, and the block reports completion with a one-cycle done pulse. It sits directly upstream of the full-adder cell: it sequences operands into that cell and consumes the cell's sum and carry outputs.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/serial_adder_fa_cell.sv | 19 +
 rtl/serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the bit-serial adder:
//   - state_t     : FSM state encoding (IDLE, RUN, DONE; 2'd3 is unused)
//   - cnt_width() : bit counter width, max(1, $clog2(width))
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A one-bit adder still needs a one-bit counter, hence the floor of 1.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell
//   Purely combinational one-bit full adder.
//   Ports:
//     x, y : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder. Operands and carry-in are captured on an
//   accepted start, then one bit pair per clock (LSB first) goes through a
//   single fa_cell. The result accumulates in a shift register and a
//   one-cycle done pulse marks completion.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     start       : add request, sampled only in IDLE
//     a, b, cin   : operands and carry-in, captured on the accepted start
//     busy        : high in RUN or DONE
//     done        : one-cycle pulse, sum/cout valid
//     sum, cout   : result (a + b + cin) mod 2^WIDTH and carry out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] rs_q, rs_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_co;

  fa_cell u_fa (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    rs_d    = rs_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cy_d    = cin;
          rs_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New sum bit enters at the MSB; written with shifts rather than a
        // concatenation so that WIDTH=1 needs no zero-width slice.
        rs_d  = (rs_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cy_d  = fa_co;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        // Unused encoding 2'd3 falls back to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      rs_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      rs_q    <= rs_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = rs_q;
  assign cout = cy_q;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

endmodule
